// File: rtl/dma_job_arbiter.sv
// Purpose: shares one host DMA channel between two job requesters, granting one job at a time and alternating on ties.
// Latency: ack/go one cycle after the IDLE sample, earliest cpl four cycles after it; a size-0 job completes one cycle after the sample.
// Backpressure: line data is steered combinationally, with dma_empty/dma_full gating the granted requester; the other requester sees no valid/ready.
//
// Ports:
//   req_valid/req_write/req_addr/req_size  per-requester job request (held until req_ack, or req_cpl for size-0)
//   req_ack/req_cpl                        one-cycle acceptance / completion pulses, one bit per requester
//   rd_valid/rd_en/rd_data                 read-line stream from the DMA to the granted requester
//   wr_ready/wr_en/wr_data                 write-line stream from the granted requester to the DMA
//   dma_*                                  host DMA channel: go pulses, latched job, pop/push, status
module dma_job_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 16,
    parameter int DATA_WIDTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*SIZE_WIDTH-1:0] req_size,
    output logic [1:0]              req_ack,
    output logic [1:0]              req_cpl,
    output logic [1:0]              rd_valid,
    input  logic [1:0]              rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              wr_ready,
    input  logic [1:0]              wr_en,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    output logic                    dma_rd_go,
    output logic                    dma_wr_go,
    output logic [ADDR_WIDTH-1:0]   dma_rd_addr,
    output logic [ADDR_WIDTH-1:0]   dma_wr_addr,
    output logic [SIZE_WIDTH-1:0]   dma_rd_size,
    output logic [SIZE_WIDTH-1:0]   dma_wr_size,
    output logic                    dma_rd_en,
    output logic                    dma_wr_en,
    input  logic [DATA_WIDTH-1:0]   dma_rd_data,
    output logic [DATA_WIDTH-1:0]   dma_wr_data,
    input  logic                    dma_empty,
    input  logic                    dma_full,
    input  logic                    dma_rd_done,
    input  logic                    dma_wr_done
);

    typedef enum logic [2:0] {IDLE, GO, SETTLE, BUSY, CPL} state_t;

    state_t                 state;
    logic                   g;
    logic                   last_g;
    logic                   op_write;
    logic [ADDR_WIDTH-1:0]  job_addr;
    logic [SIZE_WIDTH-1:0]  job_size;
    logic [1:0]             ack_r;
    logic [1:0]             cpl_r;
    logic                   rd_go_r;
    logic                   wr_go_r;

    // Candidate grant: on a tie the requester that did not win last time goes first.
    logic                   nxt_g;
    logic                   sel_write;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [SIZE_WIDTH-1:0]  sel_size;

    always_comb begin
        nxt_g     = (req_valid == 2'b11) ? ~last_g : req_valid[1];
        sel_write = req_write[nxt_g];
        sel_addr  = nxt_g ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        sel_size  = nxt_g ? req_size[2*SIZE_WIDTH-1:SIZE_WIDTH] : req_size[SIZE_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            g        <= 1'b0;
            last_g   <= 1'b1;
            op_write <= 1'b0;
            job_addr <= '0;
            job_size <= '0;
            ack_r    <= 2'b00;
            cpl_r    <= 2'b00;
            rd_go_r  <= 1'b0;
            wr_go_r  <= 1'b0;
        end else begin
            ack_r   <= 2'b00;
            cpl_r   <= 2'b00;
            rd_go_r <= 1'b0;
            wr_go_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        g        <= nxt_g;
                        last_g   <= nxt_g;
                        op_write <= sel_write;
                        job_addr <= sel_addr;
                        job_size <= sel_size;
                        if (sel_size == '0) begin
                            // Empty job: complete without touching the DMA.
                            state <= CPL;
                            cpl_r <= {nxt_g, ~nxt_g};
                        end else begin
                            state   <= GO;
                            ack_r   <= {nxt_g, ~nxt_g};
                            rd_go_r <= ~sel_write;
                            wr_go_r <= sel_write;
                        end
                    end
                end
                GO:     state <= SETTLE;
                // Done may still be high from the previous job here, so it is not looked at.
                SETTLE: state <= BUSY;
                BUSY: begin
                    if (op_write ? dma_wr_done : dma_rd_done) begin
                        state <= CPL;
                        cpl_r <= {g, ~g};
                    end
                end
                CPL:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ack     = ack_r;
    assign req_cpl     = cpl_r;
    assign dma_rd_go   = rd_go_r;
    assign dma_wr_go   = wr_go_r;
    assign dma_rd_addr = job_addr;
    assign dma_wr_addr = job_addr;
    assign dma_rd_size = job_size;
    assign dma_wr_size = job_size;

    // Data steering: only while the job is running, only to the granted requester.
    logic       steer;
    logic       rd_act;
    logic       wr_act;
    logic [1:0] g_mask;

    assign steer  = (state == SETTLE) || (state == BUSY);
    assign rd_act = steer & ~op_write;
    assign wr_act = steer & op_write;
    assign g_mask = {g, ~g};

    assign rd_valid    = (rd_act & ~dma_empty) ? g_mask : 2'b00;
    assign dma_rd_en   = rd_act & ~dma_empty & rd_en[g];
    assign rd_data     = dma_rd_data;
    assign wr_ready    = (wr_act & ~dma_full) ? g_mask : 2'b00;
    assign dma_wr_en   = wr_act & ~dma_full & wr_en[g];
    assign dma_wr_data = g ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : wr_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_dma_job_arbiter.sv
module tb_dma_job_arbiter;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid, req_write, req_ack, req_cpl;
    logic [127:0]  req_addr;
    logic [31:0]   req_size;
    logic [1:0]    rd_valid, rd_en, wr_ready, wr_en;
    logic [511:0]  rd_data, dma_rd_data, dma_wr_data;
    logic [1023:0] wr_data;
    logic          dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
    logic [63:0]   dma_rd_addr, dma_wr_addr;
    logic [15:0]   dma_rd_size, dma_wr_size;
    logic          dma_empty, dma_full, dma_rd_done, dma_wr_done;

    dma_job_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_ack(req_ack), .req_cpl(req_cpl),
        .rd_valid(rd_valid), .rd_en(rd_en), .rd_data(rd_data),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_data(wr_data),
        .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
        .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
        .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
        .dma_rd_en(dma_rd_en), .dma_wr_en(dma_wr_en),
        .dma_rd_data(dma_rd_data), .dma_wr_data(dma_wr_data),
        .dma_empty(dma_empty), .dma_full(dma_full),
        .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          req;
        logic        write;
        logic [63:0] addr;
        logic [15:0] size;
    } job_t;

    job_t go_q[$];
    int   cpl_q[$];

    int total = 0;
    int bad   = 0;

    // DMA model and bookkeeping
    int cyc = 0, go_cnt = 0, ack_cnt = 0, pops = 0, pushes = 0, wr1_cnt = 0;
    int cur_g = 0, left = 0, settle_cnt = 0, done_cyc = 0;
    int go_cyc_of[2], cpl_cyc_of[2];
    logic active = 1'b0, job_write = 1'b0, done_raised = 1'b0;
    logic stale_mode = 1'b0, toggle_full = 1'b0, phase = 1'b0;

    function automatic logic [1:0] oh(input int i);
        return (i == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock of scoreboard checking, requester behaviour and DMA modelling, at the falling edge.
    task automatic step();
        job_t e;
        int   r;
        @(negedge clk);
        cyc++;
        if (dma_rd_go || dma_wr_go) begin
            go_cnt++;
            total++;
            if (go_q.size() == 0) begin
                bad++;
                $display("FAIL go_unexpected: rd_go=%0b wr_go=%0b, required no go", dma_rd_go, dma_wr_go);
            end else begin
                e = go_q.pop_front();
                if (dma_wr_go !== e.write || dma_rd_go !== !e.write || dma_rd_addr !== e.addr ||
                    dma_wr_addr !== e.addr || dma_rd_size !== e.size || dma_wr_size !== e.size ||
                    req_ack !== oh(e.req)) begin
                    bad++;
                    $display("FAIL go_job: rd_go=%0b wr_go=%0b addr=%h size=%0d ack=%b, required write=%0b addr=%h size=%0d ack=%b",
                             dma_rd_go, dma_wr_go, dma_rd_addr, dma_rd_size, req_ack, e.write, e.addr, e.size, oh(e.req));
                end
                cur_g = e.req; job_write = e.write; left = int'(e.size);
                active = 1'b1; done_raised = 1'b0; go_cyc_of[e.req] = cyc;
                if (stale_mode) settle_cnt = 2;
                else begin dma_rd_done = 1'b0; dma_wr_done = 1'b0; end
            end
        end else if (settle_cnt > 0) begin
            settle_cnt--;
            if (settle_cnt == 0) begin dma_rd_done = 1'b0; dma_wr_done = 1'b0; end
        end
        total++;
        if (((rd_valid | wr_ready) & ~oh(cur_g)) !== 2'b00 || rd_data !== dma_rd_data) begin
            bad++;
            $display("FAIL steer: rd_valid=%b wr_ready=%b rd_data_ok=%0b, required nothing outside grant %0d and rd_data passthrough",
                     rd_valid, wr_ready, rd_data === dma_rd_data, cur_g);
        end
        if (wr_ready[1] === 1'b1) wr1_cnt++;
        if (dma_rd_en) begin pops++; left--; end
        if (dma_wr_en) begin
            pushes++; left--;
            total++;
            if (dma_full !== 1'b0 || dma_wr_data !== wr_data[cur_g*512 +: 512]) begin
                bad++;
                $display("FAIL push: full=%0b data_ok=%0b, required full=0 and data of requester %0d",
                         dma_full, dma_wr_data === wr_data[cur_g*512 +: 512], cur_g);
            end
        end
        if (req_cpl !== 2'b00) begin
            total++;
            if (cpl_q.size() == 0) begin
                bad++;
                $display("FAIL cpl_unexpected: req_cpl=%b, required none", req_cpl);
            end else begin
                r = cpl_q.pop_front();
                if (req_cpl !== oh(r)) begin
                    bad++;
                    $display("FAIL cpl_who: req_cpl=%b, required %b", req_cpl, oh(r));
                end
                cpl_cyc_of[r] = cyc;
            end
            active = 1'b0;
        end
        if (req_ack !== 2'b00) ack_cnt++;
        req_valid = req_valid & ~(req_ack | req_cpl);
        if (active && left <= 0 && !done_raised) begin
            if (job_write) dma_wr_done = 1'b1; else dma_rd_done = 1'b1;
            done_raised = 1'b1; done_cyc = cyc;
        end
        dma_empty   = !(active && !job_write && left > 0);
        dma_full    = !(active && job_write && left > 0) || (toggle_full && phase);
        phase       = !phase;
        dma_rd_data = rand512();
    endtask

    task automatic issue(input int i, input logic w, input logic [63:0] a, input logic [15:0] s);
        job_t e;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*64 +: 64] = a;
        req_size[i*16 +: 16] = s;
        e.req = i; e.write = w; e.addr = a; e.size = s;
        if (s != 16'd0) go_q.push_back(e);
        cpl_q.push_back(i);
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((go_q.size() != 0 || cpl_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        total++;
        if (go_q.size() != 0 || cpl_q.size() != 0) begin
            bad++;
            $display("FAIL idle_timeout: pending_go=%0d pending_cpl=%0d, required 0 and 0", go_q.size(), cpl_q.size());
            go_q.delete(); cpl_q.delete(); req_valid = 2'b00;
        end
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        total++;
        if ({req_ack, req_cpl, rd_valid, wr_ready, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en} !== 12'h000) begin
            bad++;
            $display("FAIL reset_pulses: ack=%b cpl=%b rdv=%b wrr=%b go=%b%b en=%b%b, required all 0",
                     req_ack, req_cpl, rd_valid, wr_ready, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en);
        end
        total++;
        if (dma_rd_addr !== 64'd0 || dma_wr_addr !== 64'd0 || dma_rd_size !== 16'd0 || dma_wr_size !== 16'd0) begin
            bad++;
            $display("FAIL reset_job: addr=%h/%h size=%0d/%0d, required 0", dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size);
        end
        rst_n = 1'b1;
        step(); step();
        total++;
        if ({req_ack, req_cpl, dma_rd_go, dma_wr_go} !== 6'd0) begin
            bad++;
            $display("FAIL idle_quiet: ack=%b cpl=%b go=%b%b, required all 0", req_ack, req_cpl, dma_rd_go, dma_wr_go);
        end
    endtask

    task automatic test_round_robin();
        wr_data = {rand512(), rand512()};
        issue(0, 1'b1, 64'h100, 16'd2);
        issue(1, 1'b0, 64'h200, 16'd3);
        run_until_idle(60);
        total++;
        if (go_cyc_of[1] - cpl_cyc_of[0] !== 2) begin
            bad++;
            $display("FAIL rr_regrant: go1-cpl0=%0d cycles, required 2", go_cyc_of[1] - cpl_cyc_of[0]);
        end
        issue(0, 1'b0, 64'h300, 16'd1);
        run_until_idle(30);
        // req0 won last, so this tie belongs to req1
        issue(1, 1'b1, 64'h500, 16'd2);
        issue(0, 1'b1, 64'h400, 16'd2);
        run_until_idle(60);
        total++;
        if (!(go_cyc_of[1] < go_cyc_of[0])) begin
            bad++;
            $display("FAIL rr_alternate: go0=%0d go1=%0d, required go1 before go0", go_cyc_of[0], go_cyc_of[1]);
        end
    endtask

    task automatic test_single_read();
        int t0;
        pops = 0;
        issue(0, 1'b0, 64'h1000, 16'd4);
        t0 = cyc;
        run_until_idle(40);
        total++;
        if (go_cyc_of[0] - t0 !== 1) begin
            bad++;
            $display("FAIL read_go_latency: %0d cycles, required 1", go_cyc_of[0] - t0);
        end
        total++;
        if (pops !== 4) begin
            bad++;
            $display("FAIL read_pops: %0d, required 4", pops);
        end
        total++;
        if (cpl_cyc_of[0] - done_cyc !== 1) begin
            bad++;
            $display("FAIL read_cpl_after_done: %0d cycles, required 1", cpl_cyc_of[0] - done_cyc);
        end
    endtask

    task automatic test_stale_done();
        stale_mode = 1'b1;
        dma_wr_done = 1'b1;
        pushes = 0;
        wr_data = {rand512(), rand512()};
        issue(1, 1'b1, 64'h2000, 16'd3);
        run_until_idle(40);
        stale_mode = 1'b0;
        total++;
        if (cpl_cyc_of[1] - go_cyc_of[1] !== 4) begin
            bad++;
            $display("FAIL stale_cpl_time: go-to-cpl=%0d cycles, required 4", cpl_cyc_of[1] - go_cyc_of[1]);
        end
        total++;
        if (cpl_cyc_of[1] - done_cyc !== 1 || pushes !== 3) begin
            bad++;
            $display("FAIL stale_redone: cpl-done=%0d pushes=%0d, required 1 and 3", cpl_cyc_of[1] - done_cyc, pushes);
        end
    endtask

    task automatic test_full_toggle();
        toggle_full = 1'b1;
        pushes = 0;
        wr1_cnt = 0;
        wr_data = {rand512(), rand512()};
        issue(0, 1'b1, 64'h3000, 16'd5);
        run_until_idle(60);
        toggle_full = 1'b0;
        total++;
        if (pushes !== 5) begin
            bad++;
            $display("FAIL full_pushes: %0d, required 5", pushes);
        end
        total++;
        if (wr1_cnt !== 0) begin
            bad++;
            $display("FAIL full_wr_ready1: seen high %0d cycles, required 0", wr1_cnt);
        end
    endtask

    task automatic test_size_zero();
        int t0, g0, a0;
        g0 = go_cnt;
        a0 = ack_cnt;
        issue(1, 1'b0, 64'h4000, 16'd0);
        t0 = cyc;
        run_until_idle(10);
        total++;
        if (go_cnt !== g0 || ack_cnt !== a0) begin
            bad++;
            $display("FAIL zero_no_dma: go=%0d ack=%0d new pulses, required 0 and 0", go_cnt - g0, ack_cnt - a0);
        end
        total++;
        if (cpl_cyc_of[1] - t0 !== 1) begin
            bad++;
            $display("FAIL zero_cpl_latency: %0d cycles, required 1", cpl_cyc_of[1] - t0);
        end
    endtask

    task automatic test_reset_mid_job();
        int g0;
        rd_en = 2'b00;
        g0 = go_cnt;
        issue(0, 1'b0, 64'h5000, 16'd8);
        for (int k = 0; k < 10 && go_cnt == g0; k++) step();
        step(); step();
        total++;
        if (rd_valid !== 2'b01) begin
            bad++;
            $display("FAIL busy_rd_valid: %b, required 01", rd_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ack, req_cpl, rd_valid, wr_ready, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en} !== 12'h000) begin
            bad++;
            $display("FAIL midjob_reset_pulses: ack=%b cpl=%b rdv=%b wrr=%b go=%b%b en=%b%b, required all 0",
                     req_ack, req_cpl, rd_valid, wr_ready, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en);
        end
        total++;
        if (dma_rd_addr !== 64'd0 || dma_rd_size !== 16'd0) begin
            bad++;
            $display("FAIL midjob_reset_job: addr=%h size=%0d, required 0", dma_rd_addr, dma_rd_size);
        end
        active = 1'b0; dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        go_q.delete(); cpl_q.delete();
        req_valid = 2'b00; rd_en = 2'b11;
        step(); step();
        rst_n = 1'b1;
        step();
        issue(0, 1'b0, 64'h7000, 16'd1);
        issue(1, 1'b0, 64'h6000, 16'd1);
        run_until_idle(40);
        total++;
        if (!(go_cyc_of[0] < go_cyc_of[1])) begin
            bad++;
            $display("FAIL post_reset_tie: go0=%0d go1=%0d, required go0 first", go_cyc_of[0], go_cyc_of[1]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_size = '0;
        rd_en = 2'b11; wr_en = 2'b11; wr_data = '0;
        dma_rd_data = '0; dma_empty = 1'b1; dma_full = 1'b1;
        dma_rd_done = 1'b0; dma_wr_done = 1'b0;
        go_cyc_of[0] = 0; go_cyc_of[1] = 0; cpl_cyc_of[0] = 0; cpl_cyc_of[1] = 0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_stale_done();
        test_full_toggle();
        test_size_zero();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_job_arbiter.md
# dma_job_arbiter

Arbitrates the single host DMA channel (read + write, cache-line granularity) between two job requesters inside the AFU: the miner's memory controller and a second host-access client, e.g. a status/result writeback engine. It accepts one job at a time (direction, virtual byte address, size in cache lines), pulses the DMA go, and steers the streaming data handshake to the granted requester. It signals a per-requester completion once the DMA reports done. Grants alternate round-robin when both requesters are pending.

## Interface
- ADDR_WIDTH, 64, virtual byte address width
- SIZE_WIDTH, 16, job size width (cache lines)
- DATA_WIDTH, 512, cache-line width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  job request per requester; held until req_ack
- req_write  in  2  job direction per requester: 0 = read from host, 1 = write to host
- req_addr  in  2*ADDR_WIDTH  start address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_size  in  2*SIZE_WIDTH  job length in lines, same slicing
- req_ack  out  2  one-cycle acceptance pulse
- req_cpl  out  2  one-cycle completion pulse
- rd_valid  out  2  line available to requester i
- rd_en  in  2  pop the line shown on rd_data
- rd_data  out  DATA_WIDTH  dma_rd_data passed through
- wr_ready  out  2  requester i may write this cycle
- wr_en  in  2  push the line on wr_data
- wr_data  in  2*DATA_WIDTH  per-requester write data
- dma_rd_go, dma_wr_go  out  1  job start pulses
- dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH  latched job address
- dma_rd_size, dma_wr_size  out  SIZE_WIDTH  latched job size
- dma_rd_en, dma_wr_en  out  1  DMA pop/push
- dma_rd_data  in  DATA_WIDTH; dma_wr_data  out  DATA_WIDTH
- dma_empty, dma_full, dma_rd_done, dma_wr_done  in  1  DMA status

## Operation
- States: IDLE, GO, SETTLE, BUSY, CPL.
- IDLE: if any req_valid, select g. If both requests are valid, g = ~last_g; otherwise g is the single valid requester. Latch op/addr/size of g, update last_g, go to GO. If the latched size is 0, go straight to CPL without touching the DMA.
- GO: req_ack[g]=1. Pulse dma_rd_go (read job) or dma_wr_go (write job) for this cycle only. Next state is SETTLE.
- SETTLE: one cycle in which done is ignored, because done from the prior job can still be stale high. Next state is BUSY.
- BUSY: wait for the done signal of the job's direction (dma_rd_done or dma_wr_done), then go to CPL.
- CPL: req_cpl[g]=1 for one cycle, then IDLE.
- Data steering is active only in SETTLE and BUSY, and only for the granted requester in the job's direction:
  - rd_valid[g] = ~dma_empty.
  - dma_rd_en = rd_en[g] & ~dma_empty.
  - wr_ready[g] = ~dma_full.
  - dma_wr_en = wr_en[g] & ~dma_full; dma_wr_data = wr_data slice g.
- The non-granted requester sees rd_valid=0 and wr_ready=0. Its rd_en and wr_en are ignored.
- Addresses and sizes drive both the read and write DMA ports from the same latched registers. They hold until the next grant.
- A requester must deassert req_valid in its req_ack cycle.
- req_valid during GO/SETTLE/BUSY/CPL waits; it is evaluated only in IDLE.

## Timing
- Reset values: state=IDLE, last_g=1 (requester 0 wins first tie), all pulses/enables 0, latched addr/size 0.
- Latency, nonzero job: request sampled in IDLE at edge N; ack/go in cycle N+1; earliest cpl at N+4 (done high in SETTLE is ignored).
- Latency, size-0 job: cpl one cycle after IDLE sample; no ack pulse, no go.
  - Requester must instead drop req_valid on req_cpl.
- Minimum gap between consecutive jobs: one IDLE cycle.
- Data-path signals (rd_valid, wr_ready, dma_rd_en, dma_wr_en) are combinational from DMA status and requester enables: zero-cycle.
- Reset mid-job: FSM returns to IDLE immediately and no cpl is issued. The DMA side is reset by the same rst_n.

## Test plan
- Single read, req0, addr 0x1000, size 4: one dma_rd_go pulse with addr 0x1000 and size 4; 4 pops steered to req0; req_cpl[0] exactly one cycle after dma_rd_done.
- Simultaneous req0 write (size 2) and req1 read (size 3) from reset: req0 granted first, req1 granted in the IDLE after req_cpl[0]. A second tie then goes to req0's opponent, i.e. strict alternation.
- Stale dma_wr_done held high from the prior job: no cpl before SETTLE completes. cpl follows done re-assertion in BUSY.
- Write with dma_full toggled every other cycle, wr_en[0] held at 1: dma_wr_en asserted only when full=0. Exactly size lines pushed; req1 wr_ready stays 0.
- Size-0 request from req1: req_cpl[1] pulses; dma_rd_go and dma_wr_go never assert.
- rst_n asserted during BUSY: all outputs return to reset values asynchronously. The next request after release is granted normally, with req0 winning the first tie.
